mem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port 4096×16 instruction/data RAM between the processor (port 0) and a secondary master (port 1, e.g. memory loader/dump or display-fetch engine). It sits between the masters and the RAM instance, sequences every access through a fixed three-state cycle, and returns read data with a one-cycle acknowledge pulse. Arbitration is round-robin or fixed-priority, selected by parameter.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port 4096x16 RAM. Every access runs IDLE->ISSUE->RESP.
// Contention is resolved by round-robin or by fixed port-0 priority, selected by FIXED_PRIO.
module mem_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [11:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [11:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,
    output logic [11:0] m_addr,
    output logic [15:0] m_data,
    output logic        m_wren,
    input  logic [15:0] m_q,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] m_addr_q, m_addr_d;
    logic [15:0] m_data_q, m_data_d;
    logic        m_wren_q, m_wren_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic [15:0] p0_rdata_q, p0_rdata_d;
    logic [15:0] p1_rdata_q, p1_rdata_d;
    logic        busy_q, busy_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        grant_s;

    // Port chosen if a grant happens this IDLE cycle; a lone requester always wins.
    always_comb begin
        grant_s = 1'b0;
        if (p0_req && p1_req) begin
            if (FIXED_PRIO != 0) begin
                grant_s = 1'b0;
            end else begin
                grant_s = ~last_q;
            end
        end else begin
            grant_s = p1_req;
        end
    end

    // Next-state and output decode for the three-state access sequence.
    always_comb begin
        state_d    = state_q;
        m_addr_d   = m_addr_q;
        m_data_d   = m_data_q;
        m_wren_d   = m_wren_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        owner_d    = owner_q;
        last_d     = last_q;
        busy_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = S_ISSUE;
                    owner_d = grant_s;
                    last_d  = grant_s;
                    if (grant_s) begin
                        m_addr_d = p1_addr;
                        m_data_d = p1_wdata;
                        m_wren_d = p1_we;
                    end else begin
                        m_addr_d = p0_addr;
                        m_data_d = p0_wdata;
                        m_wren_d = p0_we;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d  = S_RESP;
                m_wren_d = 1'b0;
                // m_wren_q still marks the access as a write; writes leave rdata untouched.
                if (!m_wren_q) begin
                    if (owner_q) begin
                        p1_rdata_d = m_q;
                    end else begin
                        p0_rdata_d = m_q;
                    end
                end else begin
                    p0_rdata_d = p0_rdata_q;
                end
                if (owner_q) begin
                    p1_ack_d = 1'b1;
                end else begin
                    p0_ack_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                m_wren_d = 1'b0;
            end
        endcase
        if (state_d != S_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State and output registers; the pointer resets to 1 so the first tie goes to port 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            m_addr_q   <= 12'h000;
            m_data_q   <= 16'h0000;
            m_wren_q   <= 1'b0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_rdata_q <= 16'h0000;
            p1_rdata_q <= 16'h0000;
            busy_q     <= 1'b0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_addr_q   <= m_addr_d;
            m_data_q   <= m_data_d;
            m_wren_q   <= m_wren_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
        end
    end

    assign m_addr   = m_addr_q;
    assign m_data   = m_data_q;
    assign m_wren   = m_wren_q;
    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: a round-robin instance (dut_rr, index 0) and a fixed-priority instance
// (dut_fp, index 1), each with its own inverted-clock RAM model.
module tb_mem_arbiter;

    typedef struct {
        int          d;
        int          p;
        logic [15:0] rd;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset  [2];
    logic        req    [2][2];
    logic        we     [2][2];
    logic [11:0] addr   [2][2];
    logic [15:0] wdata  [2][2];
    logic        ack    [2][2];
    logic [15:0] rdata  [2][2];
    logic [11:0] m_addr [2];
    logic [15:0] m_data [2];
    logic [15:0] m_q    [2];
    logic        m_wren [2];
    logic        busy   [2];
    logic        owner  [2];
    logic [15:0] mem    [2][4096];

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mon_idx;
    bit   pre_done = 1'b0;

    mem_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clock(clock), .reset(reset[0]),
        .p0_req(req[0][0]), .p0_we(we[0][0]), .p0_addr(addr[0][0]), .p0_wdata(wdata[0][0]),
        .p0_ack(ack[0][0]), .p0_rdata(rdata[0][0]),
        .p1_req(req[0][1]), .p1_we(we[0][1]), .p1_addr(addr[0][1]), .p1_wdata(wdata[0][1]),
        .p1_ack(ack[0][1]), .p1_rdata(rdata[0][1]),
        .m_addr(m_addr[0]), .m_data(m_data[0]), .m_wren(m_wren[0]), .m_q(m_q[0]),
        .busy(busy[0]), .owner(owner[0])
    );

    mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset[1]),
        .p0_req(req[1][0]), .p0_we(we[1][0]), .p0_addr(addr[1][0]), .p0_wdata(wdata[1][0]),
        .p0_ack(ack[1][0]), .p0_rdata(rdata[1][0]),
        .p1_req(req[1][1]), .p1_we(we[1][1]), .p1_addr(addr[1][1]), .p1_wdata(wdata[1][1]),
        .p1_ack(ack[1][1]), .p1_rdata(rdata[1][1]),
        .m_addr(m_addr[1]), .m_data(m_data[1]), .m_wren(m_wren[1]), .m_q(m_q[1]),
        .busy(busy[1]), .owner(owner[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM models clocked on the falling edge; the first falling edge loads the preset contents.
    always @(negedge clock) begin
        if (!pre_done) begin
            mem[0][12'h010] <= 16'hBEEF;
            for (int k = 0; k < 3; k++) begin
                mem[0][12'h200 + 12'(k)] <= 16'h1000 + 16'(k);
                mem[0][12'h300 + 12'(k)] <= 16'h2000 + 16'(k);
            end
            for (int k = 0; k < 4; k++) begin
                mem[1][12'h040 + 12'(k)] <= 16'h4000 + 16'(k);
            end
            mem[1][12'h050] <= 16'h5050;
            pre_done <= 1'b1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_wren[d]) mem[d][m_addr[d]] <= m_data[d];
                m_q[d] <= mem[d][m_addr[d]];
            end
        end
    end

    // Monitor: every ack must match the oldest pending expectation for that port.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (ack[d][p] === 1'b1) begin
                    mon_idx = -1;
                    for (int i = 0; i < sbq.size(); i++) begin
                        if (mon_idx < 0 && sbq[i].d == d && sbq[i].p == p) mon_idx = i;
                    end
                    checks++;
                    if (mon_idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_ack dut%0d p%0d at cycle %0d", d, p, cyc);
                    end else begin
                        if (rdata[d][p] !== sbq[mon_idx].rd) begin
                            errors++;
                            $display("FAIL rdata dut%0d p%0d: got %h expected %h", d, p,
                                     rdata[d][p], sbq[mon_idx].rd);
                        end
                        checks++;
                        if (owner[d] !== 1'(p)) begin
                            errors++;
                            $display("FAIL owner dut%0d p%0d: got %0d expected %0d", d, p,
                                     owner[d], p);
                        end
                        checks++;
                        if (cyc != sbq[mon_idx].cyc) begin
                            errors++;
                            $display("FAIL ack_cycle dut%0d p%0d: got %0d expected %0d", d, p,
                                     cyc, sbq[mon_idx].cyc);
                        end
                        sbq.delete(mon_idx);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic drive(input int d, input int p, input logic w, input logic [11:0] a,
                         input logic [15:0] wd, input logic [15:0] erd, input int ecyc,
                         input bit push);
        exp_t e;
        req[d][p]   = 1'b1;
        we[d][p]    = w;
        addr[d][p]  = a;
        wdata[d][p] = wd;
        if (push) begin
            e.d = d; e.p = p; e.rd = erd; e.cyc = ecyc;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_ack(input int d, input int p);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ack[d][p] !== 1'b1 && n < 40);
        if (ack[d][p] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d p%0d: got no ack expected ack within 40 cycles", d, p);
        end
    endtask

    task automatic release_port(input int d, input int p);
        req[d][p] = 1'b0;
        we[d][p]  = 1'b0;
    endtask

    task automatic single(input int d, input int p, input logic w, input logic [11:0] a,
                          input logic [15:0] wd, input logic [15:0] erd);
        drive(d, p, w, a, wd, erd, cyc + 2, 1'b1);
        wait_ack(d, p);
        release_port(d, p);
        @(negedge clock);
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("rst_m_addr%0d", d), 32'(m_addr[d]), 32'h0);
        chk($sformatf("rst_m_data%0d", d), 32'(m_data[d]), 32'h0);
        chk($sformatf("rst_m_wren%0d", d), 32'(m_wren[d]), 32'h0);
        chk($sformatf("rst_p0_ack%0d", d), 32'(ack[d][0]), 32'h0);
        chk($sformatf("rst_p1_ack%0d", d), 32'(ack[d][1]), 32'h0);
        chk($sformatf("rst_p0_rdata%0d", d), 32'(rdata[d][0]), 32'h0);
        chk($sformatf("rst_p1_rdata%0d", d), 32'(rdata[d][1]), 32'h0);
        chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'h0);
        chk($sformatf("rst_owner%0d", d), 32'(owner[d]), 32'h0);
    endtask

    initial begin
        int s;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = 12'h000; wdata[d][p] = 16'h0000;
            end
        end
        repeat (3) @(negedge clock);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        chk_reset(0);
        chk_reset(1);

        // Single read with ISSUE-cycle address check.
        drive(0, 0, 1'b0, 12'h010, 16'h0000, 16'hBEEF, cyc + 2, 1'b1);
        @(negedge clock);
        chk("issue_m_addr", 32'(m_addr[0]), 32'h010);
        chk("issue_busy", 32'(busy[0]), 32'h1);
        chk("issue_wren_rd", 32'(m_wren[0]), 32'h0);
        wait_ack(0, 0);
        chk("resp_busy", 32'(busy[0]), 32'h1);
        release_port(0, 0);
        @(negedge clock);
        chk("idle_busy", 32'(busy[0]), 32'h0);

        // Write then back-to-back read on port 1.
        drive(0, 1, 1'b1, 12'h123, 16'hA5A5, 16'h0000, cyc + 2, 1'b1);
        @(negedge clock);
        chk("wr_m_wren", 32'(m_wren[0]), 32'h1);
        chk("wr_m_addr", 32'(m_addr[0]), 32'h123);
        chk("wr_m_data", 32'(m_data[0]), 32'hA5A5);
        chk("wr_owner", 32'(owner[0]), 32'h1);
        wait_ack(0, 1);
        chk("wr_wren_drop", 32'(m_wren[0]), 32'h0);
        drive(0, 1, 1'b0, 12'h123, 16'h0000, 16'hA5A5, cyc + 3, 1'b1);
        @(negedge clock);
        chk("b2b_idle_wren", 32'(m_wren[0]), 32'h0);
        wait_ack(0, 1);
        release_port(0, 1);
        @(negedge clock);

        // Round-robin contention: six accesses alternating 0,1,0,1,0,1 every 3 cycles.
        s = cyc;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    drive(0, 0, 1'b0, 12'h200 + 12'(k), 16'h0000, 16'h1000 + 16'(k), s + 2 + 6 * k, 1'b1);
                    wait_ack(0, 0);
                end
                release_port(0, 0);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    drive(0, 1, 1'b0, 12'h300 + 12'(k), 16'h0000, 16'h2000 + 16'(k), s + 5 + 6 * k, 1'b1);
                    wait_ack(0, 1);
                end
                release_port(0, 1);
            end
        join
        @(negedge clock);

        // Fixed priority: port 1 waits until port 0 stops requesting.
        s = cyc;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    drive(1, 0, 1'b0, 12'h040 + 12'(k), 16'h0000, 16'h4000 + 16'(k), s + 2 + 3 * k, 1'b1);
                    wait_ack(1, 0);
                end
                release_port(1, 0);
            end
            begin
                drive(1, 1, 1'b0, 12'h050, 16'h0000, 16'h5050, s + 14, 1'b1);
                wait_ack(1, 1);
                release_port(1, 1);
            end
        join
        @(negedge clock);

        // Reset during ISSUE of a port-0 write: no ack, everything back to reset values.
        drive(0, 0, 1'b1, 12'h055, 16'h7777, 16'h0000, 0, 1'b0);
        @(negedge clock);
        chk("abort_issue_wren", 32'(m_wren[0]), 32'h1);
        reset[0] = 1'b1;
        release_port(0, 0);
        @(negedge clock);
        chk_reset(0);
        reset[0] = 1'b0;
        drive(0, 0, 1'b0, 12'h010, 16'h0000, 16'hBEEF, cyc + 2, 1'b1);
        drive(0, 1, 1'b0, 12'h123, 16'h0000, 16'hA5A5, cyc + 5, 1'b1);
        fork
            begin
                wait_ack(0, 0);
                release_port(0, 0);
            end
            begin
                wait_ack(0, 1);
                release_port(0, 1);
            end
        join
        @(negedge clock);

        // Boundary addresses from both ports; the idle port's rdata must not move.
        single(0, 0, 1'b1, 12'h000, 16'h1234, 16'hBEEF);
        single(0, 0, 1'b0, 12'h000, 16'h0000, 16'h1234);
        chk("p1_rdata_hold", 32'(rdata[0][1]), 32'hA5A5);
        single(0, 1, 1'b1, 12'hFFF, 16'hFEDC, 16'hA5A5);
        single(0, 1, 1'b0, 12'hFFF, 16'h0000, 16'hFEDC);
        chk("p0_rdata_hold", 32'(rdata[0][0]), 32'h1234);
        single(0, 0, 1'b0, 12'hFFF, 16'h0000, 16'hFEDC);
        single(0, 1, 1'b0, 12'h000, 16'h0000, 16'h1234);
        chk("p0_rdata_final", 32'(rdata[0][0]), 32'hFEDC);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
